// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg: direction codes, grid limits and FSM encoding shared by the move sequencer.
package move_sequencer_pkg;
  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_DOWN  = 3'b111;
  localparam logic [2:0] DIR_RIGHT = 3'b101;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_NONE  = 3'b100;
  localparam logic [2:0] GRID_MAX_X = 3'd7;
  localparam logic [1:0] GRID_MAX_Y = 2'd3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;
  // Directions are encoded so that the reverse move is the bitwise complement.
  function automatic logic [2:0] opposite(input logic [2:0] dir);
    return ~dir;
  endfunction
endpackage

// File: rtl/move_sequencer_edge_check.sv
// move_edge_check: flags whether a direction code is a real move and whether it stays on the grid.
module move_edge_check
  import move_sequencer_pkg::*;
#(
  parameter logic [2:0] MAX_X = GRID_MAX_X
) (
  input  logic [2:0] posx_i,
  input  logic [1:0] posy_i,
  input  logic [2:0] dir_i,
  output logic       in_grid_o,
  output logic       dir_legal_o
);
  assign dir_legal_o = dir_i inside {DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT};
  assign in_grid_o = !((dir_i == DIR_UP    && posy_i == 2'd0) ||
                       (dir_i == DIR_DOWN  && posy_i == GRID_MAX_Y) ||
                       (dir_i == DIR_LEFT  && posx_i == 3'd0) ||
                       (dir_i == DIR_RIGHT && posx_i >= MAX_X));
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: accepts one direction request at a time, issues it to the move datapath
// and owns the authoritative player position, with a cooldown between moves.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd12_500_000,
  parameter logic [2:0]  START_X         = 3'd0,
  parameter logic [1:0]  START_Y         = 2'd0,
  parameter logic [2:0]  MAX_X           = 3'd7,
  parameter logic [15:0] STEP_INIT       = 16'd0
) (
  input  logic        clk_50MHz_i,
  input  logic        rst_async_la_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_dir_i,
  output logic        req_ready_o,
  output logic [2:0]  mv_posx_o,
  output logic [1:0]  mv_posy_o,
  output logic [2:0]  mv_dir_o,
  output logic        mv_valid_o,
  input  logic [2:0]  mv_next_posx_i,
  input  logic [1:0]  mv_next_posy_i,
  output logic        moved_o,
  output logic        blocked_o,
  output logic [15:0] step_cnt_o
);
  logic [1:0]  state_q, state_d;
  logic [2:0]  posx_q, posx_d;
  logic [1:0]  posy_q, posy_d;
  logic [2:0]  dir_q, dir_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] step_q, step_d;
  logic        moved_q, moved_d, blocked_q, blocked_d;
  logic        in_grid, dir_legal, accept, changed;

  move_edge_check #(.MAX_X(MAX_X)) u_edge (
    .posx_i     (posx_q),
    .posy_i     (posy_q),
    .dir_i      (req_dir_i),
    .in_grid_o  (in_grid),
    .dir_legal_o(dir_legal)
  );

  assign req_ready_o = state_q == ST_IDLE;
  assign accept      = req_valid_i && req_ready_o;
  assign changed     = {mv_next_posx_i, mv_next_posy_i} != {posx_q, posy_q};
  assign mv_posx_o   = posx_q;
  assign mv_posy_o   = posy_q;
  assign mv_dir_o    = dir_q;
  assign mv_valid_o  = state_q == ST_ISSUE;
  assign moved_o     = moved_q;
  assign blocked_o   = blocked_q;
  assign step_cnt_o  = step_q;

  always_comb begin
    state_d   = state_q;
    posx_d    = posx_q;
    posy_d    = posy_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (state_q == ST_IDLE) begin
      blocked_d = accept && dir_legal && !in_grid;
      state_d   = accept && dir_legal && in_grid ? ST_ISSUE : ST_IDLE;
      dir_d     = accept && dir_legal && in_grid ? req_dir_i : dir_q;
    end else if (state_q == ST_ISSUE) begin
      posx_d    = mv_next_posx_i;
      posy_d    = mv_next_posy_i;
      moved_d   = changed;
      blocked_d = !changed;
      step_d    = changed && step_q != 16'hFFFF ? step_q + 16'd1 : step_q;
      cnt_d     = COOLDOWN_CYCLES;
      state_d   = ST_COOL;
    end else if (state_q == ST_COOL) begin
      // COOL always lasts at least one cycle, even with no cooldown configured.
      cnt_d   = cnt_q != 24'd0 ? cnt_q - 24'd1 : 24'd0;
      state_d = cnt_q <= 24'd1 ? ST_IDLE : ST_COOL;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state_q   <= ST_IDLE;
      posx_q    <= START_X;
      posy_q    <= START_Y;
      dir_q     <= DIR_NONE;
      cnt_q     <= 24'd0;
      step_q    <= STEP_INIT;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      posx_q    <= posx_d;
      posy_q    <= posy_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: scoreboard bench for move_sequencer with a behavioural move datapath.
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  typedef struct {
    logic        moved;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [15:0] step;
  } ev_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  int valid_times[$];

  logic rst_a, req_valid_a, refuse;
  logic [2:0] req_dir_a;
  logic ready_a, mv_valid_a, moved_a, blocked_a;
  logic [2:0] posx_a, dir_a, nx_a;
  logic [1:0] posy_a, ny_a;
  logic [15:0] step_a;

  logic rst_b, req_valid_b;
  logic [2:0] req_dir_b;
  logic ready_b, mv_valid_b, moved_b, blocked_b;
  logic [2:0] posx_b, dir_b, nx_b;
  logic [1:0] posy_b, ny_b;
  logic [15:0] step_b;
  logic ready_c, mv_valid_c, moved_c, blocked_c;
  logic [2:0] posx_c, dir_c, nx_c;
  logic [1:0] posy_c, ny_c;
  logic [15:0] step_c;

  function automatic logic [4:0] dp(input logic [2:0] x, input logic [1:0] y, input logic [2:0] d, input logic hold);
    logic [2:0] tx;
    logic [1:0] ty;
    tx = x;
    ty = y;
    if (!hold) begin
      if (d == DIR_RIGHT) tx = x + 3'd1;
      else if (d == DIR_LEFT) tx = x - 3'd1;
      else if (d == DIR_DOWN) ty = y + 2'd1;
      else if (d == DIR_UP) ty = y - 2'd1;
    end
    return {tx, ty};
  endfunction

  assign {nx_a, ny_a} = dp(posx_a, posy_a, dir_a, refuse);
  assign {nx_b, ny_b} = dp(posx_b, posy_b, dir_b, 1'b0);
  assign {nx_c, ny_c} = dp(posx_c, posy_c, dir_c, 1'b0);

  move_sequencer #(.COOLDOWN_CYCLES(24'd4)) dut_a (
    .clk_50MHz_i(clk), .rst_async_la_i(rst_a), .req_valid_i(req_valid_a), .req_dir_i(req_dir_a),
    .req_ready_o(ready_a), .mv_posx_o(posx_a), .mv_posy_o(posy_a), .mv_dir_o(dir_a),
    .mv_valid_o(mv_valid_a), .mv_next_posx_i(nx_a), .mv_next_posy_i(ny_a),
    .moved_o(moved_a), .blocked_o(blocked_a), .step_cnt_o(step_a)
  );

  move_sequencer #(.COOLDOWN_CYCLES(24'd0), .START_X(3'd2), .START_Y(2'd1)) dut_b (
    .clk_50MHz_i(clk), .rst_async_la_i(rst_b), .req_valid_i(req_valid_b), .req_dir_i(req_dir_b),
    .req_ready_o(ready_b), .mv_posx_o(posx_b), .mv_posy_o(posy_b), .mv_dir_o(dir_b),
    .mv_valid_o(mv_valid_b), .mv_next_posx_i(nx_b), .mv_next_posy_i(ny_b),
    .moved_o(moved_b), .blocked_o(blocked_b), .step_cnt_o(step_b)
  );

  move_sequencer #(.COOLDOWN_CYCLES(24'd0), .START_X(3'd2), .START_Y(2'd1), .STEP_INIT(16'hFFFE)) dut_c (
    .clk_50MHz_i(clk), .rst_async_la_i(rst_b), .req_valid_i(req_valid_b), .req_dir_i(req_dir_b),
    .req_ready_o(ready_c), .mv_posx_o(posx_c), .mv_posy_o(posy_c), .mv_dir_o(dir_c),
    .mv_valid_o(mv_valid_c), .mv_next_posx_i(nx_c), .mv_next_posy_i(ny_c),
    .moved_o(moved_c), .blocked_o(blocked_c), .step_cnt_o(step_c)
  );

  // Every moved/blocked pulse of dut_a must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_a) begin
      if (mv_valid_a) valid_times.push_back(cyc);
      if (moved_a || blocked_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: moved=%b blocked=%b pos=(%0d,%0d), required no pulse", moved_a, blocked_a, posx_a, posy_a);
        end else begin
          e = exp_q.pop_front();
          if ({moved_a, blocked_a, posx_a, posy_a, step_a} !== {e.moved, !e.moved, e.x, e.y, e.step}) begin
            errors++;
            $display("FAIL pulse_event: got moved=%b blocked=%b pos=(%0d,%0d) step=%0d, required moved=%b blocked=%b pos=(%0d,%0d) step=%0d",
                     moved_a, blocked_a, posx_a, posy_a, step_a, e.moved, !e.moved, e.x, e.y, e.step);
          end
        end
      end
    end
  end

  task automatic issue_a(input logic [2:0] d, input logic m, input logic [2:0] x, input logic [1:0] y, input logic [15:0] s);
    int low;
    exp_q.push_back('{m, x, y, s});
    req_valid_a = 1'b1;
    req_dir_a = d;
    @(negedge clk);
    req_valid_a = 1'b0;
    checks++;
    if ({mv_valid_a, dir_a, ready_a} !== {1'b1, d, 1'b0}) begin
      errors++;
      $display("FAIL issue_strobe: got valid=%b dir=%b ready=%b, required valid=1 dir=%b ready=0", mv_valid_a, dir_a, ready_a, d);
    end
    low = 0;
    while (!ready_a && low < 40) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 5) begin
      errors++;
      $display("FAIL cooldown_a: ready low for %0d cycles, required 5", low);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    rst_b = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_dir_a = DIR_NONE;
    req_dir_b = DIR_NONE;
    refuse = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({posx_a, posy_a, dir_a, mv_valid_a, moved_a, blocked_a, ready_a, step_a} !== {3'd0, 2'd0, DIR_NONE, 3'b000, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset_a: got pos=(%0d,%0d) dir=%b valid=%b moved=%b blocked=%b ready=%b step=%0d, required (0,0) 100 0 0 0 1 0",
               posx_a, posy_a, dir_a, mv_valid_a, moved_a, blocked_a, ready_a, step_a);
    end
    checks++;
    if ({posx_b, posy_b, dir_b, ready_b, step_b, step_c} !== {3'd2, 2'd1, DIR_NONE, 1'b1, 16'd0, 16'hFFFE}) begin
      errors++;
      $display("FAIL reset_bc: got pos=(%0d,%0d) dir=%b ready=%b step_b=%h step_c=%h, required (2,1) 100 1 0000 fffe",
               posx_b, posy_b, dir_b, ready_b, step_b, step_c);
    end
  endtask

  task automatic test_edge_block;
    logic [2:0] dirs [2];
    dirs[0] = DIR_UP;
    dirs[1] = DIR_LEFT;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, 3'd0, 2'd0, 16'd0});
      req_valid_a = 1'b1;
      req_dir_a = dirs[i];
      @(negedge clk);
      req_valid_a = 1'b0;
      checks++;
      if ({blocked_a, ready_a, mv_valid_a} !== 3'b110) begin
        errors++;
        $display("FAIL edge_block_%0d: got blocked=%b ready=%b valid=%b, required 1 1 0", i, blocked_a, ready_a, mv_valid_a);
      end
      @(negedge clk);
      checks++;
      if ({blocked_a, ready_a, posx_a, posy_a} !== {1'b0, 1'b1, 3'd0, 2'd0}) begin
        errors++;
        $display("FAIL edge_after_%0d: got blocked=%b ready=%b pos=(%0d,%0d), required 0 1 (0,0)", i, blocked_a, ready_a, posx_a, posy_a);
      end
    end
    checks++;
    if (valid_times.size() != 0) begin
      errors++;
      $display("FAIL edge_no_valid: mv_valid pulses=%0d, required 0", valid_times.size());
    end
  endtask

  task automatic test_move_right;
    exp_q.push_back('{1'b1, 3'd1, 2'd0, 16'd1});
    req_valid_a = 1'b1;
    req_dir_a = DIR_RIGHT;
    @(negedge clk);
    req_valid_a = 1'b0;
    checks++;
    if ({mv_valid_a, dir_a, ready_a} !== {1'b1, DIR_RIGHT, 1'b0}) begin
      errors++;
      $display("FAIL right_issue: got valid=%b dir=%b ready=%b, required 1 101 0", mv_valid_a, dir_a, ready_a);
    end
    @(negedge clk);
    checks++;
    if ({mv_valid_a, moved_a, posx_a, posy_a, step_a} !== {2'b01, 3'd1, 2'd0, 16'd1}) begin
      errors++;
      $display("FAIL right_result: got valid=%b moved=%b pos=(%0d,%0d) step=%0d, required 0 1 (1,0) 1", mv_valid_a, moved_a, posx_a, posy_a, step_a);
    end
    for (int i = 0; i < 10 && !ready_a; i++) @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL right_idle: ready=%b after cooldown, required 1", ready_a);
    end
  endtask

  task automatic test_refuse;
    issue_a(DIR_RIGHT, 1'b1, 3'd2, 2'd0, 16'd2);
    issue_a(DIR_RIGHT, 1'b1, 3'd3, 2'd0, 16'd3);
    refuse = 1'b1;
    issue_a(DIR_RIGHT, 1'b0, 3'd3, 2'd0, 16'd3);
    refuse = 1'b0;
    checks++;
    if ({posx_a, posy_a, step_a} !== {3'd3, 2'd0, 16'd3}) begin
      errors++;
      $display("FAIL refuse_state: got pos=(%0d,%0d) step=%0d, required (3,0) 3", posx_a, posy_a, step_a);
    end
  endtask

  task automatic test_held_down;
    int n;
    valid_times.delete();
    exp_q.push_back('{1'b1, 3'd3, 2'd1, 16'd4});
    exp_q.push_back('{1'b1, 3'd3, 2'd2, 16'd5});
    exp_q.push_back('{1'b1, 3'd3, 2'd3, 16'd6});
    exp_q.push_back('{1'b0, 3'd3, 2'd3, 16'd6});
    req_valid_a = 1'b1;
    req_dir_a = DIR_DOWN;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blocked_a && n < 60);
    req_valid_a = 1'b0;
    checks++;
    if (!blocked_a) begin
      errors++;
      $display("FAIL held_blocked: no blocked pulse within %0d cycles, required one at y=3", n);
    end
    checks++;
    if (valid_times.size() != 3) begin
      errors++;
      $display("FAIL held_valid_count: got %0d mv_valid pulses, required 3", valid_times.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (valid_times[i] - valid_times[i-1] != 6) begin
          errors++;
          $display("FAIL held_spacing_%0d: got %0d cycles, required 6", i, valid_times[i] - valid_times[i-1]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_none_undef;
    logic [2:0] codes [3];
    codes[0] = DIR_NONE;
    codes[1] = 3'b001;
    codes[2] = 3'b110;
    valid_times.delete();
    for (int i = 0; i < 3; i++) begin
      req_valid_a = 1'b1;
      req_dir_a = codes[i];
      @(negedge clk);
      req_valid_a = 1'b0;
      checks++;
      if ({ready_a, mv_valid_a, moved_a, blocked_a, posx_a, posy_a} !== {4'b1000, 3'd3, 2'd3}) begin
        errors++;
        $display("FAIL drop_%b: got ready=%b valid=%b moved=%b blocked=%b pos=(%0d,%0d), required 1 0 0 0 (3,3)",
                 codes[i], ready_a, mv_valid_a, moved_a, blocked_a, posx_a, posy_a);
      end
      @(negedge clk);
    end
    checks++;
    if (valid_times.size() != 0) begin
      errors++;
      $display("FAIL drop_valid: got %0d mv_valid pulses, required 0", valid_times.size());
    end
  endtask

  task automatic move_b(input logic [2:0] d, output int low);
    req_valid_b = 1'b1;
    req_dir_b = d;
    @(negedge clk);
    req_valid_b = 1'b0;
    low = 0;
    while (!ready_b && low < 40) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_saturate;
    int low;
    move_b(DIR_RIGHT, low);
    checks++;
    if ({low[3:0], posx_b, posy_b, step_b, step_c} !== {4'd2, 3'd3, 2'd1, 16'd1, 16'hFFFF}) begin
      errors++;
      $display("FAIL sat_first: got low=%0d pos=(%0d,%0d) step_b=%h step_c=%h, required 2 (3,1) 0001 ffff", low, posx_b, posy_b, step_b, step_c);
    end
    move_b(DIR_LEFT, low);
    checks++;
    if ({low[3:0], posx_c, posy_c, step_b, step_c} !== {4'd2, 3'd2, 2'd1, 16'd2, 16'hFFFF}) begin
      errors++;
      $display("FAIL sat_hold: got low=%0d pos=(%0d,%0d) step_b=%h step_c=%h, required 2 (2,1) 0002 ffff", low, posx_c, posy_c, step_b, step_c);
    end
  endtask

  task automatic test_reset_mid_move;
    req_valid_b = 1'b1;
    req_dir_b = DIR_DOWN;
    @(negedge clk);
    req_valid_b = 1'b0;
    checks++;
    if (mv_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: mv_valid=%b, required 1", mv_valid_b);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({posx_b, posy_b, ready_b, mv_valid_b, dir_b, step_b, moved_b} !== {3'd2, 2'd1, 2'b10, DIR_NONE, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_state: got pos=(%0d,%0d) ready=%b valid=%b dir=%b step=%0d moved=%b, required (2,1) 1 0 100 0 0",
               posx_b, posy_b, ready_b, mv_valid_b, dir_b, step_b, moved_b);
    end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({moved_b, posx_b, posy_b, step_b} !== {1'b0, 3'd2, 2'd1, 16'd0}) begin
        errors++;
        $display("FAIL midrst_after: got moved=%b pos=(%0d,%0d) step=%0d, required 0 (2,1) 0", moved_b, posx_b, posy_b, step_b);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge_block();
    test_move_right();
    test_refuse();
    test_held_down();
    test_none_undef();
    test_saturate();
    test_reset_mid_move();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
